// File: rtl/mux_seq_n_1.sv
// Registered N:1 word selector: direct random-access select or snapshot-and-stream sequence.
// Latency: 1 cycle from an accepted request to out_valid, and 1 cycle from a handshake to the next word.
// Backpressure: in sequence mode out_ready=0 holds the current word; direct mode ignores out_ready.
module mux_seq_n_1 #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 9,
  parameter int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_bus,
  input  logic                   sel_en,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   start,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  state_t            state, state_n;
  logic [SEL_W-1:0]  idx, idx_n, idx_inc;
  logic [DATA_W-1:0] out_data_n;
  logic              out_valid_n, sel_err_n, done_n, capture;
  logic              sel_ok;
  logic [DATA_W-1:0] in_word [N_IN];
  logic [DATA_W-1:0] bank    [N_IN];

  // Unpack the flat input bus into addressable words
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      in_word[k] = in_bus[k*DATA_W +: DATA_W];
    end
  end

  // The extra bit lets N_IN itself be represented when it is a power of two
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(N_IN));
  assign idx_inc = idx + 1'b1;
  assign busy    = (state == SEND);

  // Next-state and next-output decode; outputs are registered below
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    out_data_n  = out_data;
    out_valid_n = 1'b0;
    sel_err_n   = 1'b0;
    done_n      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture     = 1'b1;
          idx_n       = '0;
          state_n     = SEND;
          out_valid_n = 1'b1;
          out_data_n  = in_word[0];
        end else if (sel_en) begin
          out_valid_n = 1'b1;
          if (sel_ok) begin
            out_data_n = in_word[sel];
          end else begin
            out_data_n = '0;
            sel_err_n  = 1'b1;
          end
        end
      end
      SEND: begin
        out_valid_n = 1'b1;
        if (out_ready) begin
          if (idx == LAST) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            idx_n       = '0;
            done_n      = 1'b1;
          end else begin
            idx_n      = idx_inc;
            out_data_n = bank[idx_inc];
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // State, index and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      sel_err   <= sel_err_n;
      done      <= done_n;
    end
  end

  // Snapshot bank: frozen copy of in_bus taken when a sequence starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) bank[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_IN; k++) bank[k] <= in_word[k];
    end
  end

endmodule

// File: tb/tb_mux_seq_n_1.sv
module tb_mux_seq_n_1;
  localparam int DATA_W = 16;
  localparam int N_IN   = 9;
  localparam int SEL_W  = $clog2(N_IN);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN*DATA_W-1:0] in_bus;
  logic                   sel_en, start, out_ready;
  logic [SEL_W-1:0]       sel;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid, sel_err, busy, done;

  int tests = 0;
  int fails = 0;

  // kind: 0 = direct result, 1 = streamed word, 2 = done pulse
  typedef struct {
    int                kind;
    logic [DATA_W-1:0] data;
    logic              err;
  } item_t;

  item_t             sb[$];
  logic [DATA_W-1:0] hold_exp = '0;

  mux_seq_n_1 #(.DATA_W(DATA_W), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel_en(sel_en), .sel(sel),
    .start(start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [N_IN*DATA_W-1:0] b, input int k);
    return b[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [N_IN*DATA_W-1:0] pattern_bus();
    logic [N_IN*DATA_W-1:0] b;
    for (int k = 0; k < N_IN; k++) b[k*DATA_W +: DATA_W] = DATA_W'(16'h0010 * k + k);
    return b;
  endfunction

  function automatic logic [N_IN*DATA_W-1:0] random_bus();
    logic [N_IN*DATA_W-1:0] b;
    for (int k = 0; k < N_IN; k++) b[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return b;
  endfunction

  // Monitor: the scoreboard front says what the DUT must present this cycle
  always @(negedge clk) begin
    logic ev, ed, eb;
    if (!rst) begin
      ed = (sb.size() > 0) && (sb[0].kind == 2);
      ev = (sb.size() > 0) && (sb[0].kind != 2);
      eb = ev && (sb[0].kind == 1);
      check("done", 32'(done), 32'(ed));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("busy", 32'(busy), 32'(eb));
      if (ev) begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("sel_err", 32'(sel_err), 32'(sb[0].err));
        if (sb[0].kind == 0 || out_ready) begin
          hold_exp = sb[0].data;
          void'(sb.pop_front());
        end
      end else begin
        check("out_hold", 32'(out_data), 32'(hold_exp));
        check("sel_err_idle", 32'(sel_err), 32'(0));
      end
      if (ed) void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic direct(input logic [SEL_W-1:0] s);
    item_t it;
    sel_en    = 1'b1;
    sel       = s;
    out_ready = 1'($urandom);
    it.kind   = 0;
    it.err    = (int'(s) >= N_IN);
    it.data   = it.err ? '0 : word_of(in_bus, int'(s));
    tick();
    sel_en = 1'b0;
    sb.push_back(it);
  endtask

  // mode 0: ready always high, in_bus forced to all ones during the stream
  // mode 1: ready low on stream cycles 3..6
  // mode 2: random ready with bounded stalls
  task automatic seq(input int mode, input bit with_sel, input int abort_at);
    logic [N_IN*DATA_W-1:0] snap;
    item_t it;
    int cnt, cyc, stall;
    snap   = in_bus;
    start  = 1'b1;
    sel_en = with_sel;
    sel    = SEL_W'($urandom);
    tick();
    start  = 1'b0;
    sel_en = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      it.kind = 1; it.data = word_of(snap, k); it.err = 1'b0;
      sb.push_back(it);
    end
    it.kind = 2; it.data = '0; it.err = 1'b0;
    sb.push_back(it);
    cnt = 0; cyc = 0; stall = 0;
    while (cnt < abort_at) begin
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 3 && cyc <= 6);
        default: out_ready = (stall > 4) ? 1'b1 : 1'($urandom);
      endcase
      stall  = out_ready ? 0 : stall + 1;
      in_bus = (mode == 0) ? '1 : random_bus();
      start  = 1'($urandom);
      sel_en = 1'($urandom);
      sel    = (mode == 1) ? '0 : SEL_W'($urandom);
      tick();
      if (out_ready) cnt++;
    end
    start  = 1'b0;
    sel_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_bus = '0; sel_en = 1'b0; sel = '0; start = 1'b0; out_ready = 1'b0;
    #17;
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sel_err", 32'(sel_err), 32'(0));
    rst = 1'b0;
    tick();

    in_bus = pattern_bus();
    direct(SEL_W'(4));
    direct(SEL_W'(12));
    tick();
    seq(0, 1'b0, N_IN);
    in_bus = pattern_bus();
    seq(1, 1'b0, N_IN);
    in_bus = pattern_bus();
    seq(1, 1'b1, N_IN);
    in_bus = random_bus();
    seq(2, 1'b0, N_IN);
    in_bus = random_bus();
    seq(2, 1'b0, N_IN);

    // Abandon a stream after word5 is accepted
    in_bus = pattern_bus();
    seq(0, 1'b0, 6);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    hold_exp = '0;
    check("arst_out_data", 32'(out_data), 32'(0));
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_sel_err", 32'(sel_err), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    in_bus = pattern_bus();
    seq(0, 1'b0, N_IN);

    for (int i = 0; i < 60; i++) begin
      in_bus = random_bus();
      case ($urandom_range(0, 3))
        0, 1: direct(SEL_W'($urandom));
        2:    seq(2, 1'($urandom), N_IN);
        default: begin
          out_ready = 1'($urandom);
          tick();
        end
      endcase
    end

    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_seq_n_1.md
Name: mux_seq_n_1

Overview:
Parametrised, registered N:1 word selector for the autoencoder datapath, generalising the combinational 9:1 operand mux. It has two modes.
- Direct mode: one registered random-access select.
- Sequence mode: snapshots all N input words and streams them out in index order over a valid/ready handshake.
It sits between the weight/activation register banks and the MAC unit, so the MAC can consume one operand per accepted cycle.

Parameters:
- DATA_W, 16, width of each input word and of out_data (16-bit fixed point).
- N_IN, 9, number of input words (N_IN >= 2).
- SEL_W, $clog2(N_IN), width of sel and of the internal index counter.

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- rst, input, 1, asynchronous active-high reset.
- in_bus, input, N_IN*DATA_W, packed input words; word k = in_bus[k*DATA_W +: DATA_W].
- sel_en, input, 1, direct-mode request strobe, sampled in IDLE only.
- sel, input, SEL_W, direct-mode word index.
- start, input, 1, sequence-mode request strobe, sampled in IDLE only.
- out_data, output, DATA_W, registered selected word.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data (used in sequence mode only).
- sel_err, output, 1, one-cycle pulse: direct request with sel >= N_IN.
- busy, output, 1, high while the sequence is in progress.
- done, output, 1, one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, idx=0.
  - out_data=0, out_valid=0, sel_err=0, busy=0, done=0.
  - Snapshot bank cleared to 0.
  - Takes effect immediately, including mid-sequence; the in-flight sequence is abandoned with no done pulse.
- States:
  - IDLE: busy=0.
  - SEND: busy=1.
- IDLE, start=1 (takes priority over sel_en in the same cycle):
  - Capture all N_IN words of in_bus into the snapshot bank.
  - idx<=0, go to SEND.
  - Next cycle: out_valid=1, out_data=word0. Latency is 1 cycle.
- IDLE, sel_en=1, start=0, sel < N_IN:
  - Next cycle: out_data=in_bus word[sel], out_valid=1 for exactly one cycle.
  - out_ready is ignored in direct mode.
- IDLE, sel_en=1, start=0, sel >= N_IN:
  - Next cycle: out_data=0, out_valid=1 for one cycle, sel_err=1 for one cycle.
  - No latching of the previous value.
- IDLE, no request: out_valid=0, out_data holds its last value.
- SEND:
  - out_valid=1 and out_data=bank[idx] continuously.
  - out_ready=0: hold out_data/out_valid unchanged (stall of any length).
  - Handshake (out_valid & out_ready) with idx < N_IN-1: idx<=idx+1; the next word appears on the following cycle.
  - Handshake with idx = N_IN-1:
    - Go to IDLE, out_valid<=0, idx<=0.
    - done=1 for one cycle (the cycle after the handshake); busy falls in that same cycle.
- Requests while busy:
  - start and sel_en are ignored during SEND; no queuing.
  - in_bus changes during SEND do not affect streamed data (snapshot semantics).
- Back-to-back sequences:
  - start is accepted in the same cycle done is high, because the block is already in IDLE.
  - Minimum gap between the last accepted word and the next word0 is 2 cycles.
- Width rules: pure selection, no arithmetic. SEL_W counter compare is exact; idx never exceeds N_IN-1.
- Throughput: with out_ready held high, one word per cycle; N_IN cycles from the first out_valid to the final handshake.

Test Plan:
1. Reset then direct select: N_IN=9, words = 16'h0010*k + k (k = 0..8), sel_en=1, sel=4. Next cycle out_data=16'h0044, out_valid=1 for 1 cycle, sel_err=0.
2. Out-of-range select: sel=4'd12. Next cycle out_data=0, out_valid=1, sel_err=1 (each for one cycle); state stays IDLE.
3. Full stream with out_ready=1: start pulse, then change in_bus to all-16'hFFFF the next cycle. Outputs are 16'h0000, 16'h0011 … 16'h0088 on 9 consecutive cycles, then done=1 for 1 cycle, busy=0.
4. Backpressure: out_ready=0 for cycles 3–6 of the stream. out_data holds word2 with out_valid=1 throughout; resumes with word3 after release; still exactly 9 words and one done pulse.
5. Priority and ignore: start and sel_en together in IDLE gives sequence mode only (no sel_err). sel_en=1, sel=0 during SEND is ignored and the stream is unchanged.
6. Mid-sequence reset: assert rst asynchronously after word5 is accepted. All outputs go to 0 immediately with no done pulse; after release, start gives a fresh stream beginning at word0.
